// File: rtl/lcd_ctrl.sv
// lcd_ctrl: HD44780 8-bit bus sequencer with power-up init and a one-entry write buffer
module lcd_ctrl #(
  parameter int T_PWRUP = 750000,
  parameter int T_SU    = 4,
  parameter int T_EN    = 12,
  parameter int T_HOLD  = 4,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lcd_wr_i,
  input  logic [31:0] lcd_wdata_i,
  output logic        lcd_ready_o,
  output logic [31:0] lcd_status_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_blon_o
);
  typedef enum logic [2:0] {PWRUP, SETUP, PULSE, HOLD, EXEC, IDLE} state_t;
  // init commands, index 0 in the low byte
  localparam logic [47:0] INIT = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};
  state_t      r_state;
  logic [19:0] r_cnt;
  logic [2:0]  r_idx;
  logic        r_full, r_brs, r_ovf, r_init_done, r_rs, r_en, r_on, r_blon;
  logic [7:0]  r_bdata, r_data;
  logic [19:0] w_lim;
  logic [2:0]  w_nidx;
  logic [7:0]  w_icmd;
  logic        w_pop, w_acc, w_last, w_clr, w_unused;
  assign w_pop    = r_state == IDLE && r_full;
  assign w_acc    = lcd_wr_i && (!r_full || w_pop);
  assign w_clr    = !r_rs && (r_data == 8'h01 || r_data == 8'h02);
  assign w_nidx   = r_state == PWRUP ? 3'd0 : r_idx + 3'd1;
  assign w_icmd   = INIT[{w_nidx, 3'b000} +: 8];
  assign w_last   = r_cnt == w_lim;
  assign w_unused = ^lcd_wdata_i[29:9];
  // last count value of the current state; clear/home gets the long execution wait
  always_comb
    w_lim = r_state == PWRUP ? 20'(T_PWRUP - 1) :
            r_state == SETUP ? 20'(T_SU - 1) :
            r_state == PULSE ? 20'(T_EN - 1) :
            r_state == HOLD  ? 20'(T_HOLD - 1) :
            r_state == EXEC  ? (w_clr ? 20'(T_CLR - 1) : 20'(T_EXEC - 1)) : 20'd0;
  // pending buffer, sticky overflow and power/backlight controls
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_full  <= 1'b0;
      r_brs   <= 1'b0;
      r_bdata <= 8'h00;
      r_ovf   <= 1'b0;
      r_on    <= 1'b1;
      r_blon  <= 1'b0;
    end else begin
      if (w_acc) {r_brs, r_bdata} <= lcd_wdata_i[8:0];
      r_full <= w_acc || (r_full && !w_pop);
      r_ovf  <= r_ovf || (lcd_wr_i && !w_acc);
      if (lcd_wr_i) {r_on, r_blon} <= lcd_wdata_i[31:30];
    end
  // bus-cycle sequencer; the counter restarts on every state change
  always_ff @(posedge clk_i)
    if (rst_i) begin
      r_state     <= PWRUP;
      r_cnt       <= 20'd0;
      r_idx       <= 3'd0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_en        <= 1'b0;
    end else begin
      r_cnt <= (w_last || r_state == IDLE) ? 20'd0 : r_cnt + 20'd1;
      if (w_pop) begin
        r_state       <= SETUP;
        {r_rs, r_data} <= {r_brs, r_bdata};
      end else if (w_last)
        case (r_state)
          PWRUP: begin
            r_state <= SETUP;
            r_idx   <= w_nidx;
            r_rs    <= 1'b0;
            r_data  <= w_icmd;
          end
          SETUP: begin
            r_state <= PULSE;
            r_en    <= 1'b1;
          end
          PULSE: begin
            r_state <= HOLD;
            r_en    <= 1'b0;
          end
          HOLD: r_state <= EXEC;
          EXEC:
            if (r_init_done || r_idx == 3'd5) begin
              r_state     <= IDLE;
              r_init_done <= 1'b1;
            end else begin
              r_state <= SETUP;
              r_idx   <= w_nidx;
              r_rs    <= 1'b0;
              r_data  <= w_icmd;
            end
          default: ;
        endcase
    end
  assign lcd_ready_o  = !r_full || w_pop;
  assign lcd_status_o = {29'd0, r_ovf, r_init_done, r_state != IDLE || r_full};
  assign lcd_data_o   = r_data;
  assign lcd_rs_o     = r_rs;
  assign lcd_rw_o     = 1'b0;
  assign lcd_en_o     = r_en;
  assign lcd_on_o     = r_on;
  assign lcd_blon_o   = r_blon;
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: vector table plus bus scoreboard for lcd_ctrl
module tb_lcd_ctrl;
  localparam int P_PWRUP = 20, P_SU = 2, P_EN = 3, P_HOLD = 2, P_EXEC = 10, P_CLR = 30;
  logic        clk = 0, rst = 1, wr = 0;
  logic [31:0] wdata = 0;
  logic        ready, rs, rw, en, on, blon;
  logic [31:0] status;
  logic [7:0]  data;
  int          n_cmp = 0, n_err = 0, cyc = 0;
  logic [8:0]  q[$];
  lcd_ctrl #(.T_PWRUP(P_PWRUP), .T_SU(P_SU), .T_EN(P_EN), .T_HOLD(P_HOLD),
             .T_EXEC(P_EXEC), .T_CLR(P_CLR)) dut (
    .clk_i(clk), .rst_i(rst), .lcd_wr_i(wr), .lcd_wdata_i(wdata),
    .lcd_ready_o(ready), .lcd_status_o(status), .lcd_data_o(data),
    .lcd_rs_o(rs), .lcd_rw_o(rw), .lcd_en_o(en), .lcd_on_o(on), .lcd_blon_o(blon));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (status[0] && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(n < 2000), 1);
  endtask
  task automatic push_init();
    q.push_back(9'h038); q.push_back(9'h038); q.push_back(9'h038);
    q.push_back(9'h00C); q.push_back(9'h001); q.push_back(9'h006);
  endtask
  task automatic init_run();
    logic low = 1;
    int   n = 0;
    push_init();
    for (int i = 0; i < P_PWRUP; i++) begin
      tick();
      if (en) low = 0;
    end
    chk("pwrup_en_low", 32'(low), 1);
    while (!status[1] && n < 1000) begin
      tick();
      n++;
    end
    chk("init_done", status, 32'h2);
    chk("init_queue_empty", q.size(), 0);
  endtask
  // bus monitor: pops expected {rs,data} on each EN rise, checks widths and gaps
  int         hi_cnt, stable, rise_cyc, fall_cyc;
  logic       prev_en, prev_clr, have_prev;
  logic [8:0] last_bus;
  always @(negedge clk) begin
    logic [8:0] cur;
    cur = {rs, data};
    if (rst) begin
      prev_en   = 0;
      have_prev = 0;
      stable    = 0;
      last_bus  = cur;
    end else begin
      stable   = (cur == last_bus) ? stable + 1 : 1;
      last_bus = cur;
      chk("rw_low", 32'(rw), 0);
      if (en && !prev_en) begin
        chk("setup_time", 32'(stable > P_SU), 1);
        if (q.size() == 0) chk("unexpected_bus_cycle", 32'(cur), 32'h1ff);
        else chk("bus_value", 32'(cur), 32'(q.pop_front()));
        if (have_prev)
          chk("cmd_gap", 32'(cyc - fall_cyc >= P_HOLD + (prev_clr ? P_CLR : P_EXEC) + P_SU), 1);
        hi_cnt   = 1;
        rise_cyc = cyc;
      end else if (en) hi_cnt++;
      else if (prev_en) begin
        chk("en_width", hi_cnt, P_EN);
        fall_cyc  = cyc;
        prev_clr  = cur == 9'h001 || cur == 9'h002;
        have_prev = 1;
      end
      prev_en = en;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct {
    logic [31:0] wdata;
    logic [8:0]  bus;
    logic        on, blon;
  } vec_t;
  vec_t tbl[5];
  initial begin
    int  n, acc;
    logic allr;
    tbl[0] = '{32'h0000_0141, 9'h141, 1'b0, 1'b0};
    tbl[1] = '{32'hC000_0000, 9'h000, 1'b1, 1'b1};
    tbl[2] = '{32'h0000_0000, 9'h000, 1'b0, 1'b0};
    tbl[3] = '{32'h8000_0155, 9'h155, 1'b1, 1'b0};
    tbl[4] = '{32'h4000_0002, 9'h002, 1'b0, 1'b1};
    tick(); tick();
    chk("rst_data", data, 0);
    chk("rst_rs", rs, 0);
    chk("rst_en", en, 0);
    chk("rst_on", on, 1);
    chk("rst_blon", blon, 0);
    chk("rst_status", status, 32'h1);
    chk("rst_ready", ready, 1);
    rst = 0;
    init_run();
    foreach (tbl[i]) begin
      wait_idle();
      chk("ready_pre", ready, 1);
      wr = 1; wdata = tbl[i].wdata;
      q.push_back(tbl[i].bus);
      tick();
      acc = cyc;
      wr = 0;
      chk("on_next", on, tbl[i].on);
      chk("blon_next", blon, tbl[i].blon);
      n = 0; allr = 1;
      while (status[0] && n < 1000) begin
        if (!ready) allr = 0;
        tick();
        n++;
      end
      chk("busy_cycles", n, 1 + P_SU + P_EN + P_HOLD +
          ((tbl[i].bus == 9'h001 || tbl[i].bus == 9'h002) ? P_CLR : P_EXEC));
      chk("ready_held", 32'(allr), 1);
      chk("en_latency", rise_cyc - acc, 1 + P_SU);
      chk("status_after", status, 32'h2);
    end
    wait_idle();
    chk("b2b_ready0", ready, 1);
    wr = 1; wdata = 32'h141; q.push_back(9'h141); tick();
    chk("b2b_ready1", ready, 1);
    wdata = 32'h142; q.push_back(9'h142); tick();
    chk("b2b_ready2", ready, 0);
    wdata = 32'h143; tick();
    wr = 0;
    chk("b2b_ovf", status[2], 1);
    wait_idle();
    chk("b2b_queue_empty", q.size(), 0);
    chk("b2b_status", status, 32'h6);
    wr = 1; wdata = 32'h001; q.push_back(9'h001); tick();
    chk("clr_ready", ready, 1);
    wdata = 32'h148; q.push_back(9'h148); tick();
    wr = 0;
    wait_idle();
    chk("clr_queue_empty", q.size(), 0);
    chk("clr_last_bus", {rs, data}, 9'h148);
    wr = 1; wdata = 32'h8000_0141; q.push_back(9'h141); tick();
    wr = 0;
    n = 0;
    while (!en && n < 100) begin
      tick();
      n++;
    end
    chk("en_seen", en, 1);
    rst = 1;
    tick();
    chk("mid_rst_en", en, 0);
    chk("mid_rst_on", on, 1);
    chk("mid_rst_blon", blon, 0);
    chk("mid_rst_status", status, 32'h1);
    chk("mid_rst_data", {rs, data}, 9'h000);
    rst = 0;
    q.delete();
    init_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
